// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-3 master: FSM states, polarity constants
// and the transfer width.
package spi_pkg;

    localparam int   BYTE_W    = 8;
    localparam logic SCLK_IDLE = 1'b1;   // CPOL=1: clock idles high
    localparam logic SCLK_LOW  = 1'b0;
    localparam logic CS_ON     = 1'b0;   // chip select is active low
    localparam logic CS_OFF    = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        LAG   = 3'd4,
        GAP   = 3'd5
    } state_e;

endpackage

// File: rtl/spi_bit_timer.sv
// SCLK half-period timer: while enabled, pulses half_done on every HALF_DIV-th
// cycle; held at zero while disabled so each byte starts from a clean count.
module spi_bit_timer #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic clk27m,
    input  logic rst,
    input  logic en,
    output logic half_done
);

    localparam logic [7:0] LAST = 8'(HALF_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d     = 8'd0;
        half_done = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                half_done = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk27m or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-3 byte master with framed chip select. tx_valid/tx_ready: a byte is
// taken on any cycle both are high; the source holds tx_data/tx_last steady until then.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned HALF_DIV = 4,
    parameter int unsigned CS_LEAD  = 4,
    parameter int unsigned CS_LAG   = 4
) (
    input  logic              clk27m,
    input  logic              rst,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              tx_valid,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    input  logic              miso,
    output state_e            dbg_state
);

    localparam logic [7:0] LEAD_END = 8'(CS_LEAD - 1);
    localparam logic [7:0] LAG_END  = 8'(CS_LAG - 1);

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [2:0]          bit_q, bit_d;
    logic                high_q, high_d;
    logic [BYTE_W-1:0]   tx_sr_q, tx_sr_d;
    logic                last_q, last_d;
    logic [BYTE_W-1:0]   rx_sr_q, rx_sr_d;
    logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                cs_q, cs_d;
    logic                rdy_en_q;
    logic                half_done;
    logic                accept;

    spi_bit_timer #(.HALF_DIV(HALF_DIV)) u_timer (
        .clk27m    (clk27m),
        .rst       (rst),
        .en        (state_q == SHIFT),
        .half_done (half_done)
    );

    // rdy_en_q keeps tx_ready low until the first edge after reset release.
    assign tx_ready  = rdy_en_q && ((state_q == IDLE) || (state_q == WAIT));
    assign accept    = tx_valid && tx_ready;
    assign cs        = cs_q & ~((state_q == IDLE) && accept);
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        high_d     = high_q;
        tx_sr_d    = tx_sr_q;
        last_d     = last_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = SCLK_IDLE;
        mosi_d     = mosi_q;
        cs_d       = cs_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_sr_d = tx_data;
                    last_d  = tx_last;
                    cs_d    = CS_ON;
                    cnt_d   = 8'd0;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (cnt_q == LEAD_END) begin
                    sclk_d  = SCLK_LOW;
                    mosi_d  = tx_sr_q[BYTE_W-1];
                    bit_d   = 3'd7;
                    high_d  = 1'b0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SHIFT: begin
                sclk_d = sclk_q;
                if (half_done) begin
                    if (!high_q) begin
                        // Rising edge: the slave has held miso stable since the fall.
                        sclk_d  = SCLK_IDLE;
                        high_d  = 1'b1;
                        rx_sr_d = {rx_sr_q[BYTE_W-2:0], miso};
                    end else if (bit_q == 3'd0) begin
                        sclk_d     = SCLK_IDLE;
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sr_q;
                        cnt_d      = 8'd0;
                        state_d    = last_q ? LAG : WAIT;
                    end else begin
                        sclk_d  = SCLK_LOW;
                        high_d  = 1'b0;
                        bit_d   = bit_q - 3'd1;
                        tx_sr_d = {tx_sr_q[BYTE_W-2:0], 1'b0};
                        mosi_d  = tx_sr_q[BYTE_W-2];
                    end
                end
            end
            WAIT: begin
                if (accept) begin
                    tx_sr_d = tx_data;
                    last_d  = tx_last;
                    sclk_d  = SCLK_LOW;
                    mosi_d  = tx_data[BYTE_W-1];
                    bit_d   = 3'd7;
                    high_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            LAG: begin
                if (cnt_q == LAG_END) begin
                    cs_d    = CS_OFF;
                    cnt_d   = 8'd0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == LAG_END) begin
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = CS_OFF;
            end
        endcase
    end

    always_ff @(posedge clk27m or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            bit_q      <= 3'd0;
            high_q     <= 1'b0;
            tx_sr_q    <= '0;
            last_q     <= 1'b0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= SCLK_IDLE;
            mosi_q     <= 1'b0;
            cs_q       <= CS_OFF;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            high_q     <= high_d;
            tx_sr_q    <= tx_sr_d;
            last_q     <= last_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            rdy_en_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: per-cycle waveform model built from frame rules, directed
// scenarios with literal expectations, a fast-timing second instance, random frames.
module tb_spi_master;
  import spi_pkg::*;

  localparam int H = 4, LEADC = 4, LAGC = 4;

  // ---------------- clock / reset ----------------
  logic clk27m = 1'b0;
  logic rst = 1'b1;
  always #5 clk27m = ~clk27m;

  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0, tx_last = 1'b0;
  logic tx_ready, rx_valid, busy, sclk, cs, mosi, miso;
  logic [7:0] rx_data;
  state_e dbg_state;
  int miso_mode = 0;  // 0 loopback, 1 tied high, 2 inverted loopback, 3 tied low
  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b1 :
                (miso_mode == 2) ? ~mosi : 1'b0;

  spi_master #(.HALF_DIV(H), .CS_LEAD(LEADC), .CS_LAG(LAGC)) dut (
    .clk27m(clk27m), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .dbg_state(dbg_state)
  );

  logic [7:0] tx_data2 = 8'h00;
  logic tx_valid2 = 1'b0, tx_last2 = 1'b0;
  logic tx_ready2, rx_valid2, busy2, sclk2, cs2, mosi2;
  logic miso2 = 1'b0;
  logic [7:0] rx_data2;
  state_e dbg_state2;

  spi_master #(.HALF_DIV(1), .CS_LEAD(1), .CS_LAG(1)) dut_fast (
    .clk27m(clk27m), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_last(tx_last2), .tx_ready(tx_ready2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .busy(busy2), .sclk(sclk2), .cs(cs2), .mosi(mosi2),
    .miso(miso2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int total = 0, bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic cs, sclk, mosi, ready, busy, rxv;
    logic [7:0] rxd;
  } rec_t;

  rec_t exp_q[$];
  logic rest_wait = 1'b0;
  logic m_ready_en = 1'b0;
  logic m_mosi = 1'b0;
  logic [7:0] m_rx_data = 8'h00;
  int acc_cnt = 0;

  function automatic logic [7:0] model_rx(input logic [7:0] b);
    case (miso_mode)
      0: return b;
      1: return 8'hFF;
      2: return ~b;
      default: return 8'h00;
    endcase
  endfunction

  // Expected output waveform for every cycle after a byte is accepted.
  task automatic push_byte(input logic [7:0] b, input logic last, input logic lead,
                           input logic [7:0] rxb);
    rec_t r;
    if (lead)
      for (int i = 0; i < LEADC; i++) begin
        r = '{cs: 1'b0, sclk: 1'b1, mosi: m_mosi, ready: 1'b0, busy: 1'b1, rxv: 1'b0, rxd: 8'h00};
        exp_q.push_back(r);
      end
    for (int i = 7; i >= 0; i--)
      for (int p = 0; p < 2 * H; p++) begin
        r = '{cs: 1'b0, sclk: (p >= H), mosi: b[i], ready: 1'b0, busy: 1'b1, rxv: 1'b0, rxd: 8'h00};
        exp_q.push_back(r);
      end
    m_mosi = b[0];
    if (last) begin
      for (int i = 0; i < LAGC; i++) begin
        r = '{cs: 1'b0, sclk: 1'b1, mosi: m_mosi, ready: 1'b0, busy: 1'b1, rxv: (i == 0), rxd: rxb};
        exp_q.push_back(r);
      end
      for (int i = 0; i < LAGC; i++) begin
        r = '{cs: 1'b1, sclk: 1'b1, mosi: m_mosi, ready: 1'b0, busy: 1'b1, rxv: 1'b0, rxd: 8'h00};
        exp_q.push_back(r);
      end
      rest_wait = 1'b0;
    end else begin
      r = '{cs: 1'b0, sclk: 1'b1, mosi: m_mosi, ready: 1'b1, busy: 1'b1, rxv: 1'b1, rxd: rxb};
      exp_q.push_back(r);
      rest_wait = 1'b1;
    end
  endtask

  // Single compare process: one expected record per cycle, sampled mid-cycle.
  always @(negedge clk27m) begin
    rec_t e;
    if (rst) begin
      exp_q.delete();
      rest_wait = 1'b0;
      m_mosi = 1'b0;
      m_rx_data = 8'h00;
      m_ready_en = 1'b0;
      e = '{cs: 1'b1, sclk: 1'b1, mosi: 1'b0, ready: 1'b0, busy: 1'b0, rxv: 1'b0, rxd: 8'h00};
    end else begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else if (rest_wait)
        e = '{cs: 1'b0, sclk: 1'b1, mosi: m_mosi, ready: m_ready_en, busy: 1'b1, rxv: 1'b0, rxd: 8'h00};
      else
        e = '{cs: !(tx_valid && m_ready_en), sclk: 1'b1, mosi: m_mosi, ready: m_ready_en,
              busy: 1'b0, rxv: 1'b0, rxd: 8'h00};
      if (e.rxv) m_rx_data = e.rxd;
    end
    check("cs", cs, e.cs);
    check("sclk", sclk, e.sclk);
    check("mosi", mosi, e.mosi);
    check("tx_ready", tx_ready, e.ready);
    check("busy", busy, e.busy);
    check("rx_valid", rx_valid, e.rxv);
    check("rx_data", rx_data, m_rx_data);
    if (!rst) begin
      if (tx_valid && e.ready) begin
        acc_cnt++;
        push_byte(tx_data, tx_last, !rest_wait, model_rx(tx_data));
      end
      m_ready_en = 1'b1;
    end
  end

  // ---------------- observation helpers for literal checks ----------------
  logic [15:0] mosi_cap = 16'h0;
  logic [7:0] rx_log[$];
  int sclk_edges = 0, cs_run = 0, last_run = 0, runs = 0, gap_run = 0, last_gap = 0;

  always @(posedge sclk) mosi_cap = {mosi_cap[14:0], mosi};
  always @(sclk) sclk_edges++;
  always @(negedge clk27m) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (!cs) cs_run++;
    else if (cs_run > 0) begin last_run = cs_run; cs_run = 0; runs++; end
    if (cs && !tx_ready && !rst) gap_run++;
    else if (gap_run > 0) begin last_gap = gap_run; gap_run = 0; end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_byte(input logic [7:0] b, input logic last);
    int start, n;
    tx_data = b;
    tx_last = last;
    tx_valid = 1'b1;
    start = acc_cnt;
    n = 0;
    while (acc_cnt == start && n < 3000) begin
      @(posedge clk27m);
      #1;
      n++;
    end
    if (acc_cnt == start) check("accept_timeout", 32'(n), 32'd0);
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    tx_last = 1'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk27m);
    #1;
  endtask

  task automatic wait_model_idle();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk27m);
      #1;
      n++;
    end
    if (exp_q.size() > 0) check("idle_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int n, cs_low, runs0, nlog;
    logic [15:0] sc_pat;

    idle_cycles(3);
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 1);
    check("rst_mosi", mosi, 0);
    check("rst_ready", tx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 8'h00);
    rst = 1'b0;
    check("ready_before_edge", tx_ready, 0);
    idle_cycles(1);
    check("ready_first_edge", tx_ready, 1);
    idle_cycles(2);

    // Two-byte frame, loopback.
    miso_mode = 0;
    mosi_cap = 16'h0;
    rx_log.delete();
    runs0 = runs;
    send_byte(8'hB5, 1'b0);
    send_byte(8'h10, 1'b1);
    wait_model_idle();
    idle_cycles(2);
    check("frame2_mosi_bits", mosi_cap, 16'hB510);
    check("frame2_rx_count", rx_log.size(), 2);
    if (rx_log.size() == 2) begin
      check("frame2_rx0", rx_log[0], 8'hB5);
      check("frame2_rx1", rx_log[1], 8'h10);
    end
    check("frame2_cs_runs", runs - runs0, 1);
    check("frame2_cs_low", last_run, 1 + LEADC + 16 * H + 1 + 16 * H + LAGC);

    // Single byte with miso tied high.
    miso_mode = 1;
    sclk_edges = 0;
    last_gap = 0;
    send_byte(8'hA5, 1'b1);
    wait_model_idle();
    idle_cycles(2);
    check("single_rx", rx_data, 8'hFF);
    check("single_cs_low", last_run, 73);
    check("single_sclk_edges", sclk_edges, 16);
    check("single_gap", last_gap, 4);

    // Withheld second byte: WAIT holds indefinitely, then shifts without LEAD.
    miso_mode = 0;
    rx_log.delete();
    send_byte(8'h3C, 1'b0);
    wait_model_idle();
    idle_cycles(50);
    check("wait_state", dbg_state, WAIT);
    check("wait_cs", cs, 0);
    check("wait_sclk", sclk, 1);
    check("wait_ready", tx_ready, 1);
    send_byte(8'hC3, 1'b1);
    check("wait_no_lead", sclk, 0);
    wait_model_idle();
    idle_cycles(2);
    check("wait_rx_count", rx_log.size(), 2);
    if (rx_log.size() == 2) check("wait_rx1", rx_log[1], 8'hC3);

    // Reset during the fourth bit of 0x5A.
    send_byte(8'h5A, 1'b1);
    idle_cycles(31);
    nlog = rx_log.size();
    rst = 1'b1;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk, 1);
    check("abort_mosi", mosi, 0);
    check("abort_busy", busy, 0);
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(3);
    check("abort_no_rxv", rx_log.size(), nlog);
    send_byte(8'h81, 1'b1);
    wait_model_idle();
    idle_cycles(2);
    check("after_abort_rx", rx_data, 8'h81);

    // Fastest timing instance: HALF_DIV=1, CS_LEAD=CS_LAG=1, frame 0x00.
    check("fast_ready", tx_ready2, 1);
    tx_data2 = 8'h00;
    tx_last2 = 1'b1;
    tx_valid2 = 1'b1;
    #1;
    check("fast_cs_accept", cs2, 0);
    @(posedge clk27m);
    #1;
    tx_valid2 = 1'b0;
    n = 1;
    sc_pat = 16'h0;
    cs_low = 1;
    while (!rx_valid2 && n < 100) begin
      if (n >= 2 && n <= 17) sc_pat = {sc_pat[14:0], sclk2};
      if (!cs2) cs_low++;
      @(posedge clk27m);
      #1;
      n++;
    end
    check("fast_rxv_latency", n, 18);
    check("fast_sclk_pattern", sc_pat, 16'h5555);
    check("fast_rx_data", rx_data2, 8'h00);
    while (!cs2 && n < 200) begin
      cs_low++;
      @(posedge clk27m);
      #1;
      n++;
    end
    check("fast_cs_low", cs_low, 19);
    idle_cycles(3);

    // Random frames against the model.
    for (int f = 0; f < 40; f++) begin
      int nb;
      if ($urandom_range(0, 2) == 0) begin
        wait_model_idle();
        miso_mode = $urandom_range(0, 3);
      end
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        send_byte(8'($urandom), (k == nb - 1));
        if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 90));
      end
      if ($urandom_range(0, 1) == 0) idle_cycles($urandom_range(1, 12));
    end
    wait_model_idle();
    idle_cycles(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter HALF_DIV, default 4, meaning clk27m cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter CS_LEAD, default 4, meaning clk27m cycles from CS fall to the first SCLK falling edge (legal range 1..255).
REQ-003 SHALL have parameter CS_LAG, default 4, meaning clk27m cycles from the last SCLK rising edge to CS rise, and also the minimum CS-high gap (legal range 1..255).
REQ-004 SHALL have port clk27m  input  1  the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port tx_data  input  8  byte to transmit, MSB first.
REQ-007 SHALL have port tx_valid  input  1  tx_data/tx_last are valid.
REQ-008 SHALL have port tx_last  input  1  this byte ends the CS frame.
REQ-009 SHALL have port tx_ready  output  1  block accepts a byte this cycle.
REQ-010 SHALL have port rx_data  output  8  byte sampled from miso.
REQ-011 SHALL have port rx_valid  output  1  one-cycle strobe: rx_data is valid.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-013 SHALL have port sclk  output  1  SPI clock; idles high (mode 3).
REQ-014 SHALL have port cs  output  1  chip select, active low.
REQ-015 SHALL have port mosi  output  1  serial data to slave.
REQ-016 SHALL have port miso  input  1  serial data from slave; treated as synchronous to SCLK.

Function
REQ-017 SHALL implement the states IDLE, LEAD, SHIFT, WAIT, LAG and GAP.
REQ-018 In IDLE, SHALL assert tx_ready; on tx_valid&&tx_ready it SHALL latch tx_data and tx_last, drive cs=0 and enter LEAD.
REQ-019 In LEAD, SHALL hold cs=0 and sclk=1 for CS_LEAD cycles, then enter SHIFT.
REQ-020 In SHIFT, for each of 8 bits, SHALL drive sclk=0 and update mosi to the current bit on the falling edge, holding this for HALF_DIV cycles.
REQ-021 In SHIFT, after the low half of each bit, SHALL drive sclk=1 for HALF_DIV cycles and sample miso into the rx shift register on the sclk rising edge.
REQ-022 At the end of the 8th high half, SHALL pulse rx_valid for exactly 1 cycle with the full byte on rx_data; rx_data SHALL hold until the next strobe.
REQ-023 After a byte, if the latched tx_last=0, SHALL enter WAIT with cs=0, sclk=1 and tx_ready=1, with no timeout.
REQ-024 In WAIT, a tx_valid handshake SHALL latch the new byte and enter SHIFT directly, without a LEAD delay.
REQ-025 After a byte with latched tx_last=1, SHALL enter LAG, hold cs=0 and sclk=1 for CS_LAG cycles, then drive cs=1 and enter GAP.
REQ-026 In GAP, SHALL hold cs=1 for CS_LAG cycles with tx_ready=0, then enter IDLE.
REQ-027 tx_ready SHALL be 1 only in IDLE and WAIT; a tx_valid while tx_ready=0 SHALL be ignored, and the source SHALL hold it until accepted.
REQ-028 SHALL keep sclk=1 in every state except the low halves of SHIFT, so that no spurious SCLK edge occurs.
REQ-029 mosi SHALL hold its last driven bit outside SHIFT, and SHALL be 0 after reset.
REQ-030 Transfer latency SHALL be deterministic: with HALF_DIV=h, a single-byte frame lasts 1 (accept) + CS_LEAD + 16h + CS_LAG cycles of cs low.
REQ-031 The half-period counter and the bit counter SHALL NOT wrap mid-byte; the bit counter runs 7 down to 0 and the byte ends at 0.

Reset
REQ-032 While rst=1, SHALL force the outputs cs=1, sclk=1, mosi=0, tx_ready=0, rx_valid=0, rx_data=0x00 and busy=0, with state IDLE and all counters cleared.
REQ-033 A reset asserted mid-frame SHALL abort immediately with cs=1 asynchronously; no partial rx_valid SHALL be produced.
REQ-034 After reset release, tx_ready SHALL rise on the first clk27m edge.

Structure
REQ-035 Shared package spi_pkg SHALL hold the state enum, the SPI mode-3 polarity constants and the byte width (8).
REQ-036 One sub-module, spi_bit_timer, SHALL hold the HALF_DIV half-period counter and emit a half_done pulse; the FSM lives in spi_master.

Verification
REQ-037 Frame 0xB5 (last=0) then 0x10 (last=1), HALF_DIV=4, miso looped to mosi -> mosi bits 10110101 then 00010000, rx_valid twice with 0xB5 then 0x10, and cs low continuously across both bytes.
REQ-038 Single byte 0xA5 (last=1) with miso tied 1 -> rx_data=0xFF, cs low for exactly 1+4+64+4 cycles, 16 sclk edges, then cs high for 4 cycles before tx_ready=1.
REQ-039 Byte 0x3C (last=0), then tx_valid withheld for 50 cycles -> state stays in WAIT with cs=0, sclk=1 and tx_ready=1; a following 0xC3 (last=1) is shifted with no LEAD.
REQ-040 rst pulsed during the 4th bit of 0x5A -> cs=1, sclk=1 and mosi=0 at once, no rx_valid; a following 0x81 frame transfers correctly.
REQ-041 HALF_DIV=1 with CS_LEAD=CS_LAG=1, frame 0x00 -> sclk period of 2 cycles and rx_valid after exactly 18 cycles from the accept.
